// File: rtl/prescaled_counter.sv
// Prescaled up/down/ping-pong/one-shot counter. The prescaler paces count
// updates to one tick every prescale+1 enabled cycles.
module prescaled_counter #(
  parameter int WIDTH = 8,
  parameter int PS_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic [PS_W-1:0]  prescale,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             dir,
  output logic             active
);

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_PING    = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] MAX_CNT = '1;

  mode_e            w_mode;
  logic             w_tick;
  logic [PS_W-1:0]  r_ps_cnt,  w_ps_nxt;
  logic [WIDTH-1:0] r_count,   w_count_nxt;
  logic             r_dir,     w_dir_nxt;
  logic             r_flag,    w_flag_nxt;
  logic             r_tc,      w_tc_nxt;

  assign w_mode = mode_e'(mode);
  // prescale is compared live, so lowering it below ps_cnt ticks at once.
  assign w_tick = ena && (r_ps_cnt >= prescale);

  // NOTE: every next-state variable gets a default first, so no path can infer a latch.
  always_comb begin
    w_ps_nxt    = r_ps_cnt;
    w_count_nxt = r_count;
    w_dir_nxt   = r_dir;
    w_flag_nxt  = r_flag;
    w_tc_nxt    = 1'b0;

    if (load) begin
      w_count_nxt = load_val;
      w_ps_nxt    = '0;
      w_dir_nxt   = 1'b1;
      w_flag_nxt  = 1'b0;
    end else begin
      if (w_mode != MODE_ONESHOT) w_flag_nxt = 1'b0;
      if (ena) begin
        if (w_mode == MODE_ONESHOT && start && r_count != '0) begin
          w_flag_nxt = 1'b1;
          w_ps_nxt   = '0;
          w_dir_nxt  = 1'b0;
        end else begin
          w_ps_nxt = w_tick ? '0 : r_ps_cnt + PS_W'(1);
          case (w_mode)
            MODE_UP: begin
              w_dir_nxt = 1'b1;
              if (w_tick) begin
                w_count_nxt = r_count + WIDTH'(1);
                w_tc_nxt    = (r_count == MAX_CNT);
              end
            end
            MODE_DOWN: begin
              w_dir_nxt = 1'b0;
              if (w_tick) begin
                w_count_nxt = r_count - WIDTH'(1);
                w_tc_nxt    = (r_count == '0);
              end
            end
            MODE_PING: begin
              if (w_tick) begin
                if (r_dir) begin
                  if (r_count == MAX_CNT) begin
                    w_count_nxt = MAX_CNT - WIDTH'(1);
                    w_dir_nxt   = 1'b0;
                    w_tc_nxt    = 1'b1;
                  end else begin
                    w_count_nxt = r_count + WIDTH'(1);
                  end
                end else if (r_count == '0) begin
                  w_count_nxt = WIDTH'(1);
                  w_dir_nxt   = 1'b1;
                  w_tc_nxt    = 1'b1;
                end else begin
                  w_count_nxt = r_count - WIDTH'(1);
                end
              end
            end
            default: begin
              w_dir_nxt = 1'b0;
              if (w_tick && r_flag) begin
                w_count_nxt = r_count - WIDTH'(1);
                if (r_count == WIDTH'(1)) begin
                  w_flag_nxt = 1'b0;
                  w_tc_nxt   = 1'b1;
                end
              end
            end
          endcase
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ps_cnt <= '0;
      r_count  <= '0;
      r_dir    <= 1'b1;
      r_flag   <= 1'b0;
      r_tc     <= 1'b0;
    end else begin
      r_ps_cnt <= w_ps_nxt;
      r_count  <= w_count_nxt;
      r_dir    <= w_dir_nxt;
      r_flag   <= w_flag_nxt;
      r_tc     <= w_tc_nxt;
    end
  end

  assign count  = r_count;
  assign tc     = r_tc;
  assign dir    = r_dir;
  assign active = ena && ((w_mode != MODE_ONESHOT) || r_flag);

endmodule
